aftab_mem_arbiter: RTL and testbench
====================================

Name: aftab_mem_arbiter

Overview:
- Shares the single byte-wide memory port of mem_controller between two masters: master 0 is the aftab_core and master 1 is a secondary master (DMA or debug loader).
- Round-robin arbitration with a grant held for the owner's whole transaction.
- A bus-timeout watchdog protects against a memReady that never arrives.
- Sits between the masters and mem_controller; each master sees the same read/write/addr/data/ready handshake it would see on a direct connection.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 8, memory data width
TIMEOUT_CYCLES, 64, memReady wait limit in BUSY; 0 disables the watchdog
CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
m0Read  input  1  master 0 read request
m0Write  input  1  master 0 write request
m0Addr  input  ADDR_WIDTH  master 0 address
m0DataOut  input  DATA_WIDTH  master 0 write data
m0DataIn  output  DATA_WIDTH  read data to master 0
m0Ready  output  1  transfer-complete to master 0
m1Read / m1Write / m1Addr / m1DataOut / m1DataIn / m1Ready  as m0*, for master 1
memRead  output  1  to mem_controller readmem
memWrite  output  1  to mem_controller writemem
memAddr  output  ADDR_WIDTH  to mem_controller addressBus
memDataOut  output  DATA_WIDTH  to mem_controller dataBusIn
memDataIn  input  DATA_WIDTH  from mem_controller dataBusOut
memReady  input  1  from mem_controller memDataReady
grant  output  2  one-hot current owner; 00 when idle
busTimeout  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Request: masterX requests when mXRead | mXWrite. Each master holds its request until it sees mXReady and then drops it.
- States: IDLE, BUSY0, BUSY1. A registered lastGrant bit records the most recent owner.
- IDLE outputs: memRead = memWrite = 0, memAddr = 0, memDataOut = 0, mXReady = 0, mXDataIn = 0, grant = 00.
- IDLE -> BUSYx at the clock edge when requests are present:
  - Only one master requesting: grant that master.
  - Both requesting: grant the master != lastGrant.
- Request-to-strobe latency is exactly 1 cycle.
- BUSYx datapath: mem outputs combinationally mirror the owner's live Read/Write/Addr/DataOut. mXReady = memReady and mXDataIn = memDataIn for the owner only. The non-owner sees Ready = 0 and DataIn = 0.
- Read+write conflict: if the owner asserts Read and Write together, memWrite passes and memRead is forced 0.
- BUSYx -> IDLE when the owner's request is low at a clock edge; lastGrant <= x on that edge.
  - This gives one mandatory idle cycle between grants, so back-to-back requests from the same master also pass through IDLE.
  - A master re-requesting in that idle cycle competes in round-robin.
- Non-owner requests never preempt a granted transaction.
- Watchdog: counter clears on entry to BUSY and on every cycle with memReady = 1; otherwise it increments each BUSY cycle.
  - When counter == TIMEOUT_CYCLES−1 and memReady = 0: busTimeout = 1 for that cycle, owner Ready forced to 1, owner DataIn forced to 0, counter clears.
  - The owner then drops its request and arbitration resumes normally.
  - With TIMEOUT_CYCLES = 0 the counter is held at 0 and busTimeout stays 0.
- Reset: synchronous. On the next edge with rst = 1: state = IDLE, lastGrant = 1 (master 0 wins the first tie), counter = 0, busTimeout = 0, grant = 00. All outputs take their IDLE values, including when reset hits mid-transaction; an in-flight mem access is abandoned.
- memReady arriving while IDLE is ignored and is not forwarded.

Test Plan:
- Single master: m0Read with m0Addr = 0x800 and mem returning 0xFF after 3 cycles -> memRead rises 1 cycle after the request, memAddr = 0x800, m0DataIn = 0xFF with m0Ready on the same cycle as memReady, grant = 01 then 00.
- Simultaneous requests after reset: m0Read and m1Write (addr 0x804, data 0x5A) in the same cycle -> m0 granted first. After m0 drops: one idle cycle, then grant = 10, memWrite = 1, memDataOut = 0x5A, m1Ready mirrors memReady.
- Fairness: both masters request continuously for 4 transactions -> grant sequence 01, 10, 01, 10, separated by idle cycles.
- No preemption: m1 requests while m0 owns a transfer with 5-cycle memReady latency -> m1Ready stays 0 and memAddr stays m0Addr until m0 drops.
- Watchdog with TIMEOUT_CYCLES = 8: memReady held 0 -> on the 8th BUSY cycle busTimeout = 1 and m0Ready = 1 with m0DataIn = 0; the next request is served normally.
- Reset mid-transfer: rst asserted during BUSY1 -> next edge grant = 00 and memRead = memWrite = 0. After release with both masters requesting, master 0 wins.

Source files
------------

// File: rtl/aftab_mem_arbiter.sv
// ---------------------------------------------------------------------------
// aftab_mem_arbiter
//
// Shares the single byte-wide mem_controller port between two masters:
// master 0 (aftab_core) and master 1 (DMA / debug loader). Arbitration is
// round-robin. A grant is held for the owner's whole transaction, and a
// watchdog ends a transfer whose memReady never arrives.
//
// Handshake (identical on both master ports):
//   A master requests by raising mXRead or mXWrite and keeps Read/Write/Addr/
//   DataOut stable until it samples mXReady = 1 at a rising edge. It then
//   drops the request. mXDataIn is valid on the same cycle as mXReady.
//   The arbiter returns to IDLE on the first edge where the owner's request
//   is low. This gives one idle cycle between grants.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   m0Read/m0Write        master 0 request strobes
//   m0Addr/m0DataOut      master 0 address / write data
//   m0DataIn/m0Ready      read data / transfer-complete back to master 0
//   m1*                   same set for master 1
//   memRead/memWrite      strobes to mem_controller
//   memAddr/memDataOut    address / write data to mem_controller
//   memDataIn/memReady    read data / completion from mem_controller
//   grant                 one-hot current owner, 00 when idle
//   busTimeout            one-cycle pulse when the watchdog fires
//   dbgState              raw FSM state (0 IDLE, 1 BUSY0, 2 BUSY1)
// ---------------------------------------------------------------------------
module aftab_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0Read,
    input  logic                  m0Write,
    input  logic [ADDR_WIDTH-1:0] m0Addr,
    input  logic [DATA_WIDTH-1:0] m0DataOut,
    output logic [DATA_WIDTH-1:0] m0DataIn,
    output logic                  m0Ready,
    input  logic                  m1Read,
    input  logic                  m1Write,
    input  logic [ADDR_WIDTH-1:0] m1Addr,
    input  logic [DATA_WIDTH-1:0] m1DataOut,
    output logic [DATA_WIDTH-1:0] m1DataIn,
    output logic                  m1Ready,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memDataOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    input  logic                  memReady,
    output logic [1:0]            grant,
    output logic                  busTimeout,
    output logic [1:0]            dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arbState_t;

    // A TIMEOUT_CYCLES of 0 disables the watchdog. The last-count constant is
    // clamped so that it never goes negative in that case.
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TO_LAST_INT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    arbState_t             state;
    arbState_t             stateNext;
    logic                  lastGrant;
    logic [CNT_WIDTH-1:0]  wdCnt;
    logic                  req0;
    logic                  req1;
    logic                  timeoutHit;

    assign req0     = m0Read | m0Write;
    assign req1     = m1Read | m1Write;
    assign dbgState = state;

    // The watchdog fires only while a transfer is in flight and memReady has
    // not rescued it on this very cycle.
    assign timeoutHit = TIMEOUT_EN && (state != IDLE) && (wdCnt == TO_LAST) && !memReady;

    // ---------------------------------------------------------------
    // State register, round-robin history and watchdog counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lastGrant <= 1'b1;      // master 0 wins the first tie
            wdCnt     <= '0;
        end else begin
            state <= stateNext;
            if (state == BUSY0 && !req0) lastGrant <= 1'b0;
            if (state == BUSY1 && !req1) lastGrant <= 1'b1;
            // The counter is held at 0 in IDLE. This also clears it on entry to BUSY.
            if (!TIMEOUT_EN || state == IDLE || memReady || timeoutHit)
                wdCnt <= '0;
            else
                wdCnt <= wdCnt + CNT_ONE;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    stateNext = lastGrant ? BUSY0 : BUSY1;
                else if (req0)
                    stateNext = BUSY0;
                else if (req1)
                    stateNext = BUSY1;
            end
            BUSY0:   if (!req0) stateNext = IDLE;
            BUSY1:   if (!req1) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath mux. The owner's live signals pass straight through to the
    // memory. In IDLE every output is 0, so a stray memReady is dropped.
    // ---------------------------------------------------------------
    always_comb begin
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memAddr    = '0;
        memDataOut = '0;
        m0Ready    = 1'b0;
        m0DataIn   = '0;
        m1Ready    = 1'b0;
        m1DataIn   = '0;
        grant      = 2'b00;
        busTimeout = timeoutHit;
        case (state)
            BUSY0: begin
                grant      = 2'b01;
                memWrite   = m0Write;
                memRead    = m0Read & ~m0Write;   // write wins a read+write conflict
                memAddr    = m0Addr;
                memDataOut = m0DataOut;
                m0Ready    = memReady | timeoutHit;
                m0DataIn   = timeoutHit ? '0 : memDataIn;
            end
            BUSY1: begin
                grant      = 2'b10;
                memWrite   = m1Write;
                memRead    = m1Read & ~m1Write;
                memAddr    = m1Addr;
                memDataOut = m1DataOut;
                m1Ready    = memReady | timeoutHit;
                m1DataIn   = timeoutHit ? '0 : memDataIn;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aftab_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for aftab_mem_arbiter (watchdog limit set to 8 cycles).
// Inputs change 1 ns after each rising edge. Outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_aftab_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0Read, m0Write, m1Read, m1Write;
    logic [AW-1:0] m0Addr, m1Addr;
    logic [DW-1:0] m0DataOut, m1DataOut;
    logic [DW-1:0] m0DataIn, m1DataIn;
    logic          m0Ready, m1Ready;
    logic          memRead, memWrite;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memDataOut, memDataIn;
    logic          memReady;
    logic [1:0]    grant;
    logic          busTimeout;
    logic [1:0]    dbgState;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    aftab_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0Read(m0Read), .m0Write(m0Write), .m0Addr(m0Addr), .m0DataOut(m0DataOut),
        .m0DataIn(m0DataIn), .m0Ready(m0Ready),
        .m1Read(m1Read), .m1Write(m1Write), .m1Addr(m1Addr), .m1DataOut(m1DataOut),
        .m1DataIn(m1DataIn), .m1Ready(m1Ready),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
        .memDataOut(memDataOut), .memDataIn(memDataIn), .memReady(memReady),
        .grant(grant), .busTimeout(busTimeout), .dbgState(dbgState)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        m0Read = 0; m0Write = 0; m0Addr = '0; m0DataOut = '0;
        m1Read = 0; m1Write = 0; m1Addr = '0; m1DataOut = '0;
        memDataIn = '0; memReady = 0;

        // ---------------- reset state ----------------
        step(); step();
        rst = 1'b0;
        settle();
        check("rst_grant", grant, 2'b00);
        check("rst_memRead", memRead, 0);
        check("rst_memWrite", memWrite, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_busTimeout", busTimeout, 0);
        check("rst_state", dbgState, 2'd0);

        // memReady while idle is not forwarded
        memReady = 1; memDataIn = 8'h99;
        settle();
        check("idle_m0Ready", m0Ready, 0);
        check("idle_m0DataIn", m0DataIn, 0);
        memReady = 0; memDataIn = 0;

        // ---------------- single master read ----------------
        step();
        m0Read = 1; m0Addr = 32'h800;
        settle();
        check("t1_req_cycle_memRead", memRead, 0);
        step();                                    // BUSY0 cycle 1
        check("t1_memRead", memRead, 1);
        check("t1_memAddr", memAddr, 32'h800);
        check("t1_grant", grant, 2'b01);
        check("t1_m0Ready_wait", m0Ready, 0);
        step();                                    // cycle 2
        step();                                    // cycle 3: data returns
        memReady = 1; memDataIn = 8'hFF;
        settle();
        check("t1_m0Ready", m0Ready, 1);
        check("t1_m0DataIn", m0DataIn, 8'hFF);
        check("t1_m1Ready", m1Ready, 0);
        check("t1_m1DataIn", m1DataIn, 0);
        step();
        m0Read = 0; memReady = 0; memDataIn = 0;
        settle();
        check("t1_drop_grant", grant, 2'b01);
        step();
        check("t1_idle_grant", grant, 2'b00);

        // ---------------- simultaneous requests after reset ----------------
        rst = 1;
        step();
        rst = 0;
        m0Read = 1; m0Addr = 32'h10;
        m1Write = 1; m1Addr = 32'h804; m1DataOut = 8'h5A;
        settle();
        step();
        check("t2_first_grant", grant, 2'b01);
        check("t2_first_memRead", memRead, 1);
        check("t2_first_memAddr", memAddr, 32'h10);
        memReady = 1; memDataIn = 8'h33;
        settle();
        check("t2_m0DataIn", m0DataIn, 8'h33);
        check("t2_m1Ready_blocked", m1Ready, 0);
        step();
        m0Read = 0; memReady = 0; memDataIn = 0;
        step();
        check("t2_idle_gap", grant, 2'b00);
        check("t2_idle_memWrite", memWrite, 0);
        step();
        check("t2_second_grant", grant, 2'b10);
        check("t2_memWrite", memWrite, 1);
        check("t2_memRead", memRead, 0);
        check("t2_memAddr", memAddr, 32'h804);
        check("t2_memDataOut", memDataOut, 8'h5A);
        memReady = 1;
        settle();
        check("t2_m1Ready", m1Ready, 1);
        check("t2_m0Ready", m0Ready, 0);
        step();
        m1Write = 0; memReady = 0;
        step();
        check("t2_end_idle", grant, 2'b00);

        // ---------------- fairness ----------------
        m0Read = 1; m0Addr = 32'h100;
        m1Read = 1; m1Addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("fair_grant_%0d", i), grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("fair_addr_%0d", i), memAddr, (i % 2 == 0) ? 32'h100 : 32'h200);
            memReady = 1;
            settle();
            step();
            memReady = 0;
            if (i % 2 == 0) m0Read = 0; else m1Read = 0;
            step();
            if (i % 2 == 0) m0Read = 1; else m1Read = 1;
            settle();
            check($sformatf("fair_gap_%0d", i), grant, 2'b00);
        end
        m0Read = 0; m1Read = 0;
        step();

        // ---------------- no preemption ----------------
        m0Read = 1; m0Addr = 32'h900;
        step();
        m1Read = 1; m1Addr = 32'hA00;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("np_grant_c%0d", c), grant, 2'b01);
            check($sformatf("np_addr_c%0d", c), memAddr, 32'h900);
            check($sformatf("np_m1Ready_c%0d", c), m1Ready, 0);
            step();
        end
        memReady = 1; memDataIn = 8'h42;
        settle();
        check("np_m0Ready", m0Ready, 1);
        check("np_m1Ready", m1Ready, 0);
        check("np_m1DataIn", m1DataIn, 0);
        step();
        m0Read = 0; memReady = 0; memDataIn = 0;
        step();
        check("np_gap", grant, 2'b00);
        step();
        check("np_m1_grant", grant, 2'b10);
        check("np_m1_addr", memAddr, 32'hA00);
        memReady = 1;
        settle();
        step();
        m1Read = 0; memReady = 0;
        step();

        // ---------------- watchdog ----------------
        m0Read = 1; m0Addr = 32'hB00; memDataIn = 8'hEE;
        step();                                    // BUSY0 cycle 1
        for (int c = 1; c < 8; c++) begin
            check($sformatf("wd_quiet_c%0d", c), busTimeout, 0);
            check($sformatf("wd_m0Ready_c%0d", c), m0Ready, 0);
            step();
        end
        check("wd_busTimeout", busTimeout, 1);     // BUSY cycle 8
        check("wd_m0Ready", m0Ready, 1);
        check("wd_m0DataIn", m0DataIn, 0);
        step();
        m0Read = 0; memDataIn = 0;
        settle();
        check("wd_after_pulse", busTimeout, 0);
        step();
        check("wd_idle", grant, 2'b00);
        m0Read = 1; m0Addr = 32'hC00;
        step();
        check("wd_next_grant", grant, 2'b01);
        check("wd_next_memRead", memRead, 1);
        memReady = 1; memDataIn = 8'h77;
        settle();
        check("wd_next_m0DataIn", m0DataIn, 8'h77);
        check("wd_next_busTimeout", busTimeout, 0);
        step();
        m0Read = 0; memReady = 0; memDataIn = 0;
        step();

        // ---------------- read+write conflict ----------------
        m0Read = 1; m0Write = 1; m0Addr = 32'hE00; m0DataOut = 8'hC3;
        step();
        check("rw_memWrite", memWrite, 1);
        check("rw_memRead", memRead, 0);
        check("rw_memDataOut", memDataOut, 8'hC3);
        memReady = 1;
        settle();
        step();
        m0Read = 0; m0Write = 0; memReady = 0;
        step();

        // ---------------- reset mid-transfer ----------------
        m1Write = 1; m1Addr = 32'hD00; m1DataOut = 8'h11;
        step();
        check("rm_busy1", grant, 2'b10);
        rst = 1; m0Read = 1; m0Addr = 32'hF00; memReady = 1;
        step();
        check("rm_grant", grant, 2'b00);
        check("rm_memRead", memRead, 0);
        check("rm_memWrite", memWrite, 0);
        check("rm_m1Ready", m1Ready, 0);
        rst = 0; memReady = 0;
        step();
        check("rm_m0_wins", grant, 2'b01);
        check("rm_m0_addr", memAddr, 32'hF00);
        m0Read = 0; m1Write = 0;
        step();
        step();
        check("rm_final_idle", grant, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
